// File: rtl/mips_multicycle_control.sv
// Moore main-control FSM for the multicycle MIPS datapath.
// Optional addi support is built when MIPS_CTRL_ADDI_EN is defined.
module mips_multicycle_control (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] Opcode,
  output logic       IorD,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       Branch,
  output logic [1:0] PCSrc,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic [3:0] State
);

  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpJ     = 6'b000010;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;

  typedef enum logic [3:0] {
    StFetch   = 4'd0,
    StDecode  = 4'd1,
    StMemAdr  = 4'd2,
    StMemRd   = 4'd3,
    StMemWb   = 4'd4,
    StMemWr   = 4'd5,
    StExecute = 4'd6,
    StAluWb   = 4'd7,
    StBranch  = 4'd8,
    StAddiEx  = 4'd9,
    StAddiWb  = 4'd10,
    StJump    = 4'd11
  } state_t;

  state_t r_state;
  state_t w_next;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= StFetch;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = StFetch;
    case (r_state)
      StFetch:  w_next = StDecode;
      StDecode: begin
        case (Opcode)
          OpLw, OpSw: w_next = StMemAdr;
          OpRtype:    w_next = StExecute;
          OpBeq:      w_next = StBranch;
`ifdef MIPS_CTRL_ADDI_EN
          OpAddi:     w_next = StAddiEx;
`endif
          OpJ:        w_next = StJump;
          default:    w_next = StFetch;
        endcase
      end
      StMemAdr:  w_next = (Opcode == OpLw) ? StMemRd : StMemWr;
      StMemRd:   w_next = StMemWb;
      StExecute: w_next = StAluWb;
`ifdef MIPS_CTRL_ADDI_EN
      StAddiEx:  w_next = StAddiWb;
`endif
      default:   w_next = StFetch;
    endcase
  end

  // Outputs decode the state directly; reset only masks the strobes so the
  // first FETCH after release already drives IRWrite/PCWrite.
  always_comb begin
    IorD     = 1'b0;
    MemWrite = 1'b0;
    IRWrite  = 1'b0;
    PCWrite  = 1'b0;
    Branch   = 1'b0;
    PCSrc    = 2'b00;
    ALUSrcA  = 1'b0;
    ALUSrcB  = 2'b00;
    ALUOp    = 2'b00;
    RegDst   = 1'b0;
    MemtoReg = 1'b0;
    RegWrite = 1'b0;
    case (r_state)
      StFetch: begin
        IRWrite = 1'b1;
        PCWrite = 1'b1;
        ALUSrcB = 2'b01;
      end
      StDecode: ALUSrcB = 2'b11;
      StMemAdr: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      StMemRd: IorD = 1'b1;
      StMemWb: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
      end
      StMemWr: begin
        IorD     = 1'b1;
        MemWrite = 1'b1;
      end
      StExecute: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b10;
      end
      StAluWb: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
      end
      StBranch: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b01;
        PCSrc   = 2'b01;
        Branch  = 1'b1;
      end
`ifdef MIPS_CTRL_ADDI_EN
      StAddiEx: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      StAddiWb: RegWrite = 1'b1;
`endif
      StJump: begin
        PCWrite = 1'b1;
        PCSrc   = 2'b10;
      end
      default: ;
    endcase
    if (reset) begin
      PCWrite  = 1'b0;
      IRWrite  = 1'b0;
      RegWrite = 1'b0;
      MemWrite = 1'b0;
      Branch   = 1'b0;
    end
  end

  assign State = r_state;

endmodule
